// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences one trap-entry (interrupt or exception) or MRET
// event at a time through drain, CSR commit and fetch redirect phases.
// Outputs are decoded from the state register and the latched event only.
// The redirect target additionally reads mtvec/mepc while in REDIRECT.

module trap_sequencer #(
  parameter int unsigned MAX_DRAIN_CYCLES = 16,
  parameter bit          VECTORED_ENABLE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_request,
  input  logic [31:0] exception_cause,
  input  logic [31:0] exception_program_counter,
  input  logic        interrupt_pending,
  input  logic [31:0] interrupt_program_counter,
  input  logic        machine_return_request,
  input  logic        pipeline_empty,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        busy,
  output logic        fetch_stall,
  output logic        pipeline_flush,
  output logic        csr_exception_enable,
  output logic [31:0] csr_exception_cause,
  output logic [31:0] csr_exception_program_counter,
  output logic        csr_machine_return_enable,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DRAIN    = 2'b01,
    ST_COMMIT   = 2'b10,
    ST_REDIRECT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_INT  = 2'b01,
    EV_EXC  = 2'b10,
    EV_MRET = 2'b11
  } kind_t;

  // Counter is wide enough to hold MAX_DRAIN_CYCLES-1, the index of the last
  // permitted drain cycle; it saturates there instead of wrapping.
  localparam int unsigned     CNT_W      = $clog2(MAX_DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAX_DRAIN_CYCLES - 1);
  localparam logic [31:0]     INT_CAUSE  = 32'h8000_0007;

  // Trap target: aligned base, plus a cause-indexed offset only for
  // interrupts in vectored mode. The add wraps modulo 2^32.
  function automatic logic [31:0] trap_target(
    input logic [31:0] tvec,
    input logic [29:0] cause_low,
    input logic        is_interrupt
  );
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (VECTORED_ENABLE && is_interrupt && (tvec[1:0] == 2'b01)) begin
      trap_target = base + {cause_low, 2'b00};
    end else begin
      trap_target = base;
    end
  endfunction

  state_t            state_r;
  state_t            state_s;
  kind_t             kind_r;
  kind_t             kind_s;
  logic [31:0]       cause_r;
  logic [31:0]       cause_s;
  logic [31:0]       pc_r;
  logic [31:0]       pc_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              timeout_r;
  logic              timeout_hit_s;
  logic              unused_ok_s;

  // mepc low bits are dropped by the alignment of the return target.
  assign unused_ok_s = ^mepc[1:0];

  // Next-state selection and event capture priority (interrupt > exception > mret).
  always_comb begin
    state_s       = state_r;
    kind_s        = kind_r;
    cause_s       = cause_r;
    pc_s          = pc_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (interrupt_pending) begin
          kind_s  = EV_INT;
          cause_s = INT_CAUSE;
          pc_s    = interrupt_program_counter;
          state_s = ST_DRAIN;
        end else if (exception_request) begin
          kind_s  = EV_EXC;
          cause_s = exception_cause;
          pc_s    = exception_program_counter;
          state_s = ST_DRAIN;
        end else if (machine_return_request) begin
          kind_s  = EV_MRET;
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pipeline_empty) begin
          state_s = ST_COMMIT;
        end else if (cnt_r == DRAIN_LAST) begin
          state_s       = ST_COMMIT;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        state_s = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and latched event; reset abandons any event in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      kind_r  <= EV_NONE;
      cause_r <= 32'd0;
      pc_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      kind_r  <= kind_s;
      cause_r <= cause_s;
      pc_r    <= pc_s;
    end
  end

  // Drain cycle counter: zero outside DRAIN so every drain starts from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_DRAIN) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != DRAIN_LAST) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky drain timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  // Output decode from the state register and the latched event.
  always_comb begin
    busy                          = 1'b0;
    fetch_stall                   = 1'b0;
    pipeline_flush                = 1'b0;
    csr_exception_enable          = 1'b0;
    csr_exception_cause           = 32'd0;
    csr_exception_program_counter = 32'd0;
    csr_machine_return_enable     = 1'b0;
    redirect_valid                = 1'b0;
    redirect_pc                   = 32'd0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_DRAIN: begin
        busy           = 1'b1;
        fetch_stall    = 1'b1;
        pipeline_flush = (cnt_r == {CNT_W{1'b0}});
      end
      ST_COMMIT: begin
        busy        = 1'b1;
        fetch_stall = 1'b1;
        if (kind_r == EV_MRET) begin
          csr_machine_return_enable = 1'b1;
        end else if (kind_r != EV_NONE) begin
          csr_exception_enable          = 1'b1;
          csr_exception_cause           = cause_r;
          csr_exception_program_counter = pc_r;
        end else begin
          csr_exception_enable = 1'b0;
        end
      end
      ST_REDIRECT: begin
        busy           = 1'b1;
        fetch_stall    = 1'b1;
        redirect_valid = 1'b1;
        if (kind_r == EV_MRET) begin
          redirect_pc = {mepc[31:2], 2'b00};
        end else begin
          redirect_pc = trap_target(mtvec, cause_r[29:0], kind_r == EV_INT);
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign drain_timeout = timeout_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: event-level reference model based on
// cycle numbers (accept cycle, drain start, commit cycle), directed scenarios
// with literal expectations, then randomized traffic.

module tb_trap_sequencer;

  localparam int MAXD = 16;
  localparam int K_INT = 0;
  localparam int K_EXC = 1;
  localparam int K_MRET = 2;

  logic        clk;
  logic        rst;
  logic        exception_request;
  logic [31:0] exception_cause;
  logic [31:0] exception_program_counter;
  logic        interrupt_pending;
  logic [31:0] interrupt_program_counter;
  logic        machine_return_request;
  logic        pipeline_empty;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        busy;
  logic        fetch_stall;
  logic        pipeline_flush;
  logic        csr_exception_enable;
  logic [31:0] csr_exception_cause;
  logic [31:0] csr_exception_program_counter;
  logic        csr_machine_return_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;

  trap_sequencer #(.MAX_DRAIN_CYCLES(MAXD), .VECTORED_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .exception_request(exception_request),
    .exception_cause(exception_cause),
    .exception_program_counter(exception_program_counter),
    .interrupt_pending(interrupt_pending),
    .interrupt_program_counter(interrupt_program_counter),
    .machine_return_request(machine_return_request),
    .pipeline_empty(pipeline_empty),
    .mtvec(mtvec), .mepc(mepc),
    .busy(busy), .fetch_stall(fetch_stall), .pipeline_flush(pipeline_flush),
    .csr_exception_enable(csr_exception_enable),
    .csr_exception_cause(csr_exception_cause),
    .csr_exception_program_counter(csr_exception_program_counter),
    .csr_machine_return_enable(csr_machine_return_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_timeout(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one in-flight event described by cycle numbers.
  bit          m_active = 1'b0;
  int          m_kind = 0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_pc = 32'd0;
  int          m_start = 0;
  int          m_commit = -1;
  bit          m_to = 1'b0;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Compare the current cycle against the model, advance the model using the
  // inputs driven for this cycle, then move to the next cycle's negedge.
  task automatic step();
    logic        e_flush, e_cee, e_cmre, e_rv;
    logic [31:0] e_rpc, base;
    #1;
    e_flush = m_active && (m_commit < 0) && (cyc == m_start);
    e_cee   = m_active && (cyc == m_commit) && (m_kind != K_MRET);
    e_cmre  = m_active && (cyc == m_commit) && (m_kind == K_MRET);
    e_rv    = m_active && (m_commit >= 0) && (cyc == m_commit + 1);
    e_rpc   = 32'd0;
    if (e_rv) begin
      if (m_kind == K_MRET) begin
        e_rpc = mepc & 32'hFFFF_FFFC;
      end else begin
        base = mtvec & 32'hFFFF_FFFC;
        if (m_kind == K_INT && mtvec[1:0] == 2'b01) e_rpc = base + (m_cause << 2);
        else e_rpc = base;
      end
    end
    chk1("busy", busy, m_active);
    chk1("fetch_stall", fetch_stall, m_active);
    chk1("pipeline_flush", pipeline_flush, e_flush);
    chk1("csr_exception_enable", csr_exception_enable, e_cee);
    chk32("csr_exception_cause", csr_exception_cause, e_cee ? m_cause : 32'd0);
    chk32("csr_exception_pc", csr_exception_program_counter, e_cee ? m_pc : 32'd0);
    chk1("csr_machine_return_enable", csr_machine_return_enable, e_cmre);
    chk1("redirect_valid", redirect_valid, e_rv);
    chk32("redirect_pc", redirect_pc, e_rpc);
    chk1("drain_timeout", drain_timeout, m_to);
    if (rst) begin
      m_active = 1'b0;
      m_to     = 1'b0;
    end else if (!m_active) begin
      if (interrupt_pending || exception_request || machine_return_request) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_commit = -1;
        if (interrupt_pending) begin
          m_kind = K_INT; m_cause = 32'h8000_0007; m_pc = interrupt_program_counter;
        end else if (exception_request) begin
          m_kind = K_EXC; m_cause = exception_cause; m_pc = exception_program_counter;
        end else begin
          m_kind = K_MRET;
        end
      end
    end else if (m_commit < 0) begin
      if (pipeline_empty) begin
        m_commit = cyc + 1;
      end else if (cyc - m_start == MAXD - 1) begin
        m_commit = cyc + 1;
        m_to     = 1'b1;
      end
    end else if (cyc == m_commit + 1) begin
      m_active = 1'b0;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_requests();
    exception_request      = 1'b0;
    interrupt_pending      = 1'b0;
    machine_return_request = 1'b0;
  endtask

  int stuck = 0;

  initial begin
    rst = 1'b1;
    clear_requests();
    exception_cause = 32'd0;
    exception_program_counter = 32'd0;
    interrupt_program_counter = 32'd0;
    pipeline_empty = 1'b1;
    mtvec = 32'd0;
    mepc = 32'd0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    step();
    rst = 1'b0;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_timeout", drain_timeout, 1'b0);
    chk32("reset_redirect_pc", redirect_pc, 32'd0);

    // Exception path
    exception_request = 1'b1; exception_cause = 32'd2;
    exception_program_counter = 32'h100; mtvec = 32'h200; pipeline_empty = 1'b1;
    step();
    chk1("exc_flush_c1", pipeline_flush, 1'b1);
    clear_requests();
    step();
    chk1("exc_cee_c2", csr_exception_enable, 1'b1);
    chk32("exc_cause_c2", csr_exception_cause, 32'd2);
    chk32("exc_pc_c2", csr_exception_program_counter, 32'h100);
    step();
    chk1("exc_rv_c3", redirect_valid, 1'b1);
    chk32("exc_rpc_c3", redirect_pc, 32'h200);
    step();
    chk1("exc_busy_c4", busy, 1'b0);

    // Vectored interrupt
    interrupt_pending = 1'b1; interrupt_program_counter = 32'h44; mtvec = 32'h1001;
    step();
    clear_requests();
    step();
    chk32("vint_cause", csr_exception_cause, 32'h8000_0007);
    chk32("vint_pc", csr_exception_program_counter, 32'h44);
    step();
    chk32("vint_rpc", redirect_pc, 32'h101C);
    step();

    // Priority: all three together
    interrupt_pending = 1'b1; exception_request = 1'b1; machine_return_request = 1'b1;
    exception_cause = 32'd11; mtvec = 32'h200;
    step();
    clear_requests();
    step();
    chk1("prio_cee", csr_exception_enable, 1'b1);
    chk1("prio_no_mret", csr_machine_return_enable, 1'b0);
    chk32("prio_cause", csr_exception_cause, 32'h8000_0007);
    step();
    chk1("prio_no_mret_rd", csr_machine_return_enable, 1'b0);
    step();

    // MRET path
    machine_return_request = 1'b1; mepc = 32'h304;
    step();
    clear_requests();
    step();
    chk1("mret_cmre", csr_machine_return_enable, 1'b1);
    chk1("mret_no_cee", csr_exception_enable, 1'b0);
    step();
    chk1("mret_cmre_off", csr_machine_return_enable, 1'b0);
    chk32("mret_rpc", redirect_pc, 32'h304);
    step();

    // Drain timeout
    pipeline_empty = 1'b0; exception_request = 1'b1; exception_cause = 32'd5;
    step();
    clear_requests();
    for (int i = 0; i < MAXD - 1; i++) begin
      step();
      chk1("to_still_drain", csr_exception_enable, 1'b0);
    end
    chk1("to_not_yet", drain_timeout, 1'b0);
    step();
    chk1("to_commit", csr_exception_enable, 1'b1);
    chk1("to_flag", drain_timeout, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk1("to_sticky", drain_timeout, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("to_cleared", drain_timeout, 1'b0);

    // Reset mid-DRAIN
    pipeline_empty = 1'b0; exception_request = 1'b1;
    step();
    clear_requests();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rmid_busy", busy, 1'b0);
    chk1("rmid_stall", fetch_stall, 1'b0);
    pipeline_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("rmid_no_cee", csr_exception_enable, 1'b0);
      chk1("rmid_no_rv", redirect_valid, 1'b0);
    end

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      interrupt_pending = ($urandom_range(0, 7) == 0);
      exception_request = ($urandom_range(0, 4) == 0);
      machine_return_request = ($urandom_range(0, 5) == 0);
      exception_cause = $urandom;
      exception_program_counter = $urandom;
      interrupt_program_counter = $urandom;
      if (stuck > 0) stuck--;
      else if ($urandom_range(0, 149) == 0) stuck = $urandom_range(10, 40);
      pipeline_empty = (stuck > 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      if (!m_active) begin
        mtvec = $urandom;
        mepc = $urandom;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
